// File: rtl/mux_4_way_arb_if.sv
// Stream bundle for the 4-way round-robin merge: four upstream channels in,
// one tagged stream out. The arbiter takes the slave side.
interface mux_4_way_arb_if #(
    parameter int WIDTH = 16
);
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [1:0]         out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/mux_4_way_arb.sv
// Four-into-one valid/ready merge with round-robin grant, optional packet lock,
// and a registered output stage tagged with the source channel index.
module mux_4_way_arb #(
    parameter int WIDTH    = 16,
    parameter bit LOCK_PKT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_4_way_arb_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         rr_ptr_reg, rr_ptr_next;
    logic [1:0]         lock_ch_reg, lock_ch_next;
    logic               out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]   out_data_reg, out_data_next;
    logic               out_last_reg, out_last_next;
    logic [1:0]         out_sel_reg, out_sel_next;

    logic [1:0]         grant;
    logic               grant_vld;
    logic               load_en;
    logic               accept;

    assign load_en = !out_valid_reg || bus.out_ready;

    // Descending scan so the channel closest to rr_ptr is the last writer and wins.
    always_comb begin
        grant     = 2'd0;
        grant_vld = 1'b0;
        if (state_reg == LOCK) begin
            grant     = lock_ch_reg;
            grant_vld = 1'b1;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (bus.in_valid[rr_ptr_reg + 2'(i)]) begin
                    grant     = rr_ptr_reg + 2'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            assign bus.in_ready[gi] = rst_n && load_en && grant_vld && (grant == 2'(gi));
        end
    endgenerate

    assign accept = grant_vld && load_en && bus.in_valid[grant];

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        lock_ch_next   = lock_ch_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        out_sel_next   = out_sel_reg;
        if (accept) begin
            out_valid_next = 1'b1;
            out_data_next  = bus.in_data[int'(grant)*WIDTH +: WIDTH];
            out_last_next  = bus.in_last[grant];
            out_sel_next   = grant;
            if (LOCK_PKT && !bus.in_last[grant]) begin
                state_next   = LOCK;
                lock_ch_next = grant;
            end else begin
                state_next  = IDLE;
                rr_ptr_next = grant + 2'd1;
            end
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 2'd0;
            lock_ch_reg   <= 2'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_sel_reg   <= 2'd0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            lock_ch_reg   <= lock_ch_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            out_sel_reg   <= out_sel_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_sel   = out_sel_reg;
endmodule

// File: tb/tb_mux_4_way_arb.sv
// Bench for mux_4_way_arb: directed scenarios plus a randomized run, all compared
// against a cycle-level behavioural model of the arbitration rules.
module tb_mux_4_way_arb;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mux_4_way_arb_if #(.WIDTH(16)) bus();

    mux_4_way_arb #(.WIDTH(16), .LOCK_PKT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: priority pointer, locked channel (-1 = none), output beat.
    int          m_ptr;
    int          m_lock;
    bit          m_ov;
    logic [15:0] m_od;
    bit          m_ol;
    int          m_os;

    function automatic void model_reset();
        m_ptr = 0; m_lock = -1; m_ov = 0; m_od = 16'h0; m_ol = 0; m_os = 0;
    endfunction

    function automatic int m_grant();
        if (m_lock >= 0) return m_lock;
        for (int i = 0; i < 4; i++)
            if (bus.in_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int g;
        r = 4'b0000;
        g = m_grant();
        if (rst_n && (!m_ov || bus.out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void set_data(int k, logic [15:0] v);
        bus.in_data[k*16 +: 16] = v;
    endfunction

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic cycle();
        int g;
        bit acc;
        g   = m_grant();
        acc = rst_n && g >= 0 && (!m_ov || bus.out_ready) && bus.in_valid[g];
        @(posedge clk);
        if (rst_n) begin
            if (acc) begin
                m_ov = 1;
                m_od = bus.in_data[g*16 +: 16];
                m_ol = bus.in_last[g];
                m_os = g;
                if (!bus.in_last[g]) m_lock = g;
                else begin m_lock = -1; m_ptr = (g + 1) % 4; end
                $display("beat: ch%0d data=%h last=%0b", g, m_od, m_ol);
            end else if (bus.out_ready) begin
                m_ov = 0;
            end
        end
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        bus.in_valid = 4'b1111;
        bus.in_last  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_data(k, 16'h1000 + 16'(k));
        #1;
        checks++;
        if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 16'h0 || bus.out_sel !== 2'd0 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got data=%h sel=%0d last=%b expected 0/0/0", bus.out_data, bus.out_sel, bus.out_last);
        end
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b expected 0001", bus.in_ready); end
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rr_in_ready c=%0d: got %b expected %b", c, bus.in_ready, m_ready()); end
            checks++;
            if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rr_out_valid c=%0d: got %b expected %b", c, bus.out_valid, m_ov); end
            if (m_ov) begin
                checks++;
                if (bus.out_sel !== 2'(m_os) || bus.out_data !== 16'h1000 + 16'(m_os)) begin
                    errors++; $display("FAIL rr_out c=%0d: got sel=%0d data=%h expected sel=%0d data=%h", c, bus.out_sel, bus.out_data, m_os, 16'h1000 + 16'(m_os));
                end
            end
            cycle();
        end
    endtask

    task automatic test_packet_lock();
        int b;
        logic [3:0] rdy;
        drain();
        b = 0;
        bus.in_last = 4'b0001;
        set_data(0, 16'h3100);
        for (int c = 0; c < 6; c++) begin
            bus.in_valid[2] = (b < 3);
            bus.in_last[2]  = (b == 2);
            set_data(2, 16'h3000 + 16'(b));
            bus.in_valid[0] = (c >= 2);
            bus.in_valid[1] = 1'b0;
            bus.in_valid[3] = 1'b0;
            #1;
            rdy = bus.in_ready;
            checks++;
            if (rdy !== m_ready()) begin errors++; $display("FAIL pkt_in_ready c=%0d: got %b expected %b", c, rdy, m_ready()); end
            if (b > 0 && b < 3) begin
                checks++;
                if (rdy !== 4'b0100) begin errors++; $display("FAIL pkt_locked c=%0d: got %b expected 0100", c, rdy); end
            end
            if (c == 3) begin
                checks++;
                if (rdy !== 4'b0001) begin errors++; $display("FAIL pkt_after_last: got %b expected 0001", rdy); end
            end
            if (m_ov) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== m_od || bus.out_last !== m_ol) begin
                    errors++; $display("FAIL pkt_out c=%0d: got v=%b data=%h last=%b expected 1 %h %b", c, bus.out_valid, bus.out_data, bus.out_last, m_od, m_ol);
                end
            end
            cycle();
            if (rdy[2]) b++;
        end
    endtask

    task automatic test_backpressure();
        int b;
        int exp;
        logic [3:0] rdy;
        drain();
        b = 0;
        exp = 0;
        bus.in_valid  = 4'b0010;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 6) bus.out_ready = 1'b1;
            set_data(1, 16'h2000 + 16'(b));
            #1;
            rdy = bus.in_ready;
            checks++;
            if (rdy !== m_ready()) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b expected %b", c, rdy, m_ready()); end
            if (c >= 1 && c < 6) begin
                checks++;
                if (rdy !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h2000) begin
                    errors++; $display("FAIL bp_stall c=%0d: got rdy=%b v=%b data=%h expected 0000 1 2000", c, rdy, bus.out_valid, bus.out_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_data !== 16'h2000 + 16'(exp)) begin errors++; $display("FAIL bp_sequence: got %h expected %h", bus.out_data, 16'h2000 + 16'(exp)); end
                exp++;
            end
            cycle();
            if (rdy[1]) b++;
        end
        checks++;
        if (b - exp != 1 || exp < 5) begin errors++; $display("FAIL bp_count: got accepted=%0d delivered=%0d expected one in flight, >=5 delivered", b, exp); end
    endtask

    task automatic test_rr_wrap();
        drain();
        bus.in_valid = 4'b1000;
        bus.in_last  = 4'b1111;
        set_data(3, 16'h5003);
        set_data(0, 16'h5000);
        #1;
        checks++;
        if (bus.in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ch3: got %b expected 1000", bus.in_ready); end
        cycle();
        bus.in_valid = 4'b1001;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ch0: got %b expected 0001", bus.in_ready); end
        checks++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 16'h5003) begin errors++; $display("FAIL wrap_out3: got sel=%0d data=%h expected 3 5003", bus.out_sel, bus.out_data); end
        cycle();
        checks++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 16'h5000) begin errors++; $display("FAIL wrap_out0: got sel=%0d data=%h expected 0 5000", bus.out_sel, bus.out_data); end
    endtask

    task automatic test_reset_mid();
        drain();
        bus.in_valid = 4'b0010;
        bus.in_last  = 4'b0000;
        set_data(1, 16'h4001);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
            errors++; $display("FAIL midrst_async: got v=%b rdy=%b expected 0 0000", bus.out_valid, bus.in_ready);
        end
        cycle();
        rst_n = 1'b1;
        bus.in_valid = 4'b0011;
        bus.in_last  = 4'b1111;
        set_data(0, 16'h4000);
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b expected 0001", bus.in_ready); end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 16'h4000) begin
            errors++; $display("FAIL midrst_out: got v=%b sel=%0d data=%h expected 1 0 4000", bus.out_valid, bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = 4'($urandom);
            bus.in_last   = 4'($urandom);
            bus.in_data   = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (bus.in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, bus.in_ready, m_ready()); end
            checks++;
            if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid c=%0d: got %b expected %b", c, bus.out_valid, m_ov); end
            if (m_ov) begin
                checks++;
                if (bus.out_data !== m_od || bus.out_last !== m_ol || bus.out_sel !== 2'(m_os)) begin
                    errors++; $display("FAIL rnd_out c=%0d: got data=%h last=%b sel=%0d expected %h %b %0d", c, bus.out_data, bus.out_last, bus.out_sel, m_od, m_ol, m_os);
                end
            end
            cycle();
        end
    endtask

    initial begin
        bus.in_valid  = 4'b0000;
        bus.in_last   = 4'b0000;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_rr_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
